// File: rtl/hamming_secded_dec_pipe.sv
// Purpose: pipelined SECDED Hamming decoder that corrects single errors, flags double errors and keeps saturating error counts.
// Latency: 2 cycles from input handshake to out_valid with no backpressure; 1 word per cycle throughput.
// Backpressure: valid/ready on both sides; in_ready is combinational from out_ready, and outputs hold while stalled.
module hamming_secded_dec_pipe #(
  parameter int DATA_W = 26,
  parameter int P_W    = 5,
  parameter int CNT_W  = 16,
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [P_W-1:0]    syndrome,
  output logic [P_W-1:0]    err_pos,
  output logic              err_single,
  output logic              err_double,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  // Every Hamming position must be addressable by the syndrome.
  if ((2 ** P_W) < CODE_W) begin : g_bad_cfg
    $error("hamming_secded_dec_pipe: 2**P_W must be >= DATA_W+P_W+1");
  end

  // Mask of codeword positions whose index has bit b set; syndrome bit b is
  // the parity of in_code under this mask. Bit 0 (overall parity) never set.
  function automatic logic [CODE_W-1:0] syn_mask(input int b);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (((i >> b) & 1) == 1) begin
        m = m | (CODE_W'(1) << i);
      end
    end
    return m;
  endfunction

  // Codeword position of payload bit j: the j-th non-power-of-two position.
  function automatic int data_pos(input int j);
    int k;
    int pos;
    k   = 0;
    pos = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (k == j) begin
          pos = i;
        end
        k++;
      end
    end
    return pos;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic adv1, adv2, in_fire, out_fire;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  // Reads 1 while reset is held so upstream is never stalled by a flushing decoder.
  assign in_ready = adv1 || !rst_n;
  assign in_fire  = in_valid && adv1;
  assign out_fire = out_valid_q && out_ready;

  // ---------------------------------------------------------------------
  // Stage 1: syndrome and overall parity of the incoming word
  // ---------------------------------------------------------------------
  logic [P_W-1:0]    syn_in;
  logic              par_in;

  for (genvar b = 0; b < P_W; b++) begin : g_syn
    localparam logic [CODE_W-1:0] MASK = syn_mask(b);
    assign syn_in[b] = ^(in_code & MASK);
  end

  assign par_in = ^in_code;

  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [P_W-1:0]    s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic              s1_cen_q, s1_cen_d;

  // Stage 1 loads on an input handshake; its valid follows in_valid whenever it may advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    s1_cen_d   = s1_cen_q;
    if (adv1) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_code_d = in_code;
      s1_syn_d  = syn_in;
      s1_par_d  = par_in;
      s1_cen_d  = correct_en;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: classify, correct and extract payload
  // ---------------------------------------------------------------------
  logic              syn_nz;
  logic              in_range;
  logic              cls_single;
  logic              cls_double;
  logic [P_W-1:0]    cls_pos;
  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] fixed;
  logic [DATA_W-1:0] data_ext;

  assign syn_nz   = |s1_syn_q;
  assign in_range = int'(s1_syn_q) <= (CODE_W - 1);

  // Error classification from (syndrome, overall parity); only an in-range
  // single error with correction enabled produces a flip mask.
  always_comb begin
    cls_single = 1'b0;
    cls_double = 1'b0;
    cls_pos    = '0;
    flip       = '0;
    if (!syn_nz) begin
      // Overall parity bit itself is wrong; payload is unaffected.
      cls_single = s1_par_q;
    end else if (s1_par_q) begin
      if (in_range) begin
        cls_single = 1'b1;
        cls_pos    = s1_syn_q;
        if (s1_cen_q) begin
          flip = CODE_W'(1) << s1_syn_q;
        end
      end else begin
        // Syndrome points past the codeword: more than one bit flipped.
        cls_double = 1'b1;
      end
    end else begin
      cls_double = 1'b1;
      cls_pos    = s1_syn_q;
    end
  end

  assign fixed = s1_code_q ^ flip;

  for (genvar j = 0; j < DATA_W; j++) begin : g_ext
    localparam int DP = data_pos(j);
    logic [CODE_W-1:0] sh;
    assign sh          = fixed >> DP;
    assign data_ext[j] = sh[0];
  end

  logic [DATA_W-1:0] data_q, data_d;
  logic [P_W-1:0]    syn_q, syn_d;
  logic [P_W-1:0]    pos_q, pos_d;
  logic              single_q, single_d;
  logic              double_q, double_d;

  // Output registers load when stage 1 advances and hold while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    syn_d       = syn_q;
    pos_d       = pos_q;
    single_d    = single_q;
    double_d    = double_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d   = data_ext;
        syn_d    = s1_syn_q;
        pos_d    = cls_pos;
        single_d = cls_single;
        double_d = cls_double;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

  // Saturating counters bumped on delivered results; a clear pulse beats a coincident increment.
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (clr_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_fire) begin
      if (single_q && (cnt_corr_q != '1)) begin
        cnt_corr_d = cnt_corr_q + CNT_W'(1);
      end
      if (double_q && (cnt_uncorr_q != '1)) begin
        cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
      end
    end
  end

  // All state registers; synchronous reset flushes in-flight words and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s1_cen_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      syn_q        <= '0;
      pos_q        <= '0;
      single_q     <= 1'b0;
      double_q     <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s1_cen_q     <= s1_cen_d;
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      syn_q        <= syn_d;
      pos_q        <= pos_d;
      single_q     <= single_d;
      double_q     <= double_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign syndrome   = syn_q;
  assign err_pos    = pos_q;
  assign err_single = single_q;
  assign err_double = double_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Bench for hamming_secded_dec_pipe: default 32-bit instance driven through a scoreboard,
// plus a narrow instance (DATA_W=8, P_W=4, CNT_W=2) for out-of-range syndrome and saturation.
// Outputs are sampled on the falling edge or 1 time unit after the rising edge.
module tb_hamming_secded_dec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // default instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_code = '0;
  logic        correct_en = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] data_out;
  logic [4:0]  syndrome;
  logic [4:0]  err_pos;
  logic        err_single;
  logic        err_double;
  logic        clr_cnt = 1'b0;
  logic [15:0] cnt_corr;
  logic [15:0] cnt_uncorr;

  // narrow instance
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [12:0] b_in_code = '0;
  logic        b_correct_en = 1'b1;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [7:0]  b_data_out;
  logic [3:0]  b_syndrome;
  logic [3:0]  b_err_pos;
  logic        b_err_single;
  logic        b_err_double;
  logic        b_clr_cnt = 1'b0;
  logic [1:0]  b_cnt_corr;
  logic [1:0]  b_cnt_uncorr;

  hamming_secded_dec_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .correct_en(correct_en),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .syndrome(syndrome),
    .err_pos(err_pos), .err_single(err_single), .err_double(err_double),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  hamming_secded_dec_pipe #(.DATA_W(8), .P_W(4), .CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code), .correct_en(b_correct_en),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out), .syndrome(b_syndrome),
    .err_pos(b_err_pos), .err_single(b_err_single), .err_double(b_err_double),
    .clr_cnt(b_clr_cnt), .cnt_corr(b_cnt_corr), .cnt_uncorr(b_cnt_uncorr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode of a 32-bit word: {data[25:0], syndrome[4:0], pos[4:0], single, double}
  function automatic logic [37:0] model(input logic [31:0] c, input logic cen);
    logic [4:0]  s;
    logic        p;
    logic [31:0] f;
    logic [25:0] d;
    logic [4:0]  pos;
    logic        sg;
    logic        db;
    int          k;
    s = '0;
    for (int i = 1; i < 32; i++) if (c[i]) s = s ^ 5'(i);
    p = ^c;
    f = c; sg = 1'b0; db = 1'b0; pos = '0;
    if (s == 0) begin
      sg = p;
    end else if (p) begin
      sg = 1'b1; pos = s;
      if (cen) f[s] = ~f[s];
    end else begin
      db = 1'b1; pos = s;
    end
    k = 0; d = '0;
    for (int i = 1; i < 32; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = f[i];
        k++;
      end
    end
    return {d, s, pos, sg, db};
  endfunction

  // Scoreboard monitor on the falling edge
  logic [37:0] sb_q[$];
  logic [15:0] m_corr = '0;
  logic [15:0] m_uncorr = '0;

  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      chk("cnt_corr", cnt_corr, m_corr);
      chk("cnt_uncorr", cnt_uncorr, m_uncorr);
      if (!rst_n) begin
        sb_q.delete();
        m_corr = '0;
        m_uncorr = '0;
      end else begin
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_out", out_valid, 1'b0);
          end else begin
            chk("out_word", {data_out, syndrome, err_pos, err_single, err_double}, sb_q[0]);
            if (out_ready) begin
              e = sb_q.pop_front();
              if (!clr_cnt) begin
                if (e[1] && m_corr != 16'hFFFF) m_corr++;
                if (e[0] && m_uncorr != 16'hFFFF) m_uncorr++;
              end
            end
          end
        end
        if (clr_cnt) begin
          m_corr = '0;
          m_uncorr = '0;
        end
        if (in_valid && in_ready) sb_q.push_back(model(in_code, correct_en));
      end
    end
  end

  // Present one word and hold it until accepted; returns at posedge+1
  task automatic send(input logic [31:0] c, input logic cen);
    int n;
    in_valid = 1'b1; in_code = c; correct_en = cen; n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Narrow-instance word with fixed-latency checks; optional clear on its output handshake
  task automatic bsend(input logic [12:0] c, input logic doclr, input logic [17:0] exp);
    b_in_valid = 1'b1; b_in_code = c; b_correct_en = 1'b1;
    @(negedge clk);
    chk("b_in_ready", b_in_ready, 1'b1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b_lat1", b_out_valid, 1'b0);
    @(posedge clk); #1;
    chk("b_lat2", b_out_valid, 1'b1);
    chk("b_word", {b_data_out, b_syndrome, b_err_pos, b_err_single, b_err_double}, exp);
    b_clr_cnt = doclr;
    @(posedge clk); #1;
    b_clr_cnt = 1'b0;
    chk("b_drained", b_out_valid, 1'b0);
  endtask

  initial begin
    logic done;
    int   n;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cnt_corr", cnt_corr, 16'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // directed words: clean, bit-0 error, corrected/uncorrected d0, double error
    send(32'h0000_0000, 1'b1);
    send(32'h0000_0001, 1'b1);
    send(32'h0000_0008, 1'b1);
    send(32'h0000_0008, 1'b0);
    send(32'h0000_0006, 1'b1);
    idle(4);
    chk("t3_cnt_corr", cnt_corr, 16'd3);
    chk("t3_cnt_uncorr", cnt_uncorr, 16'd1);
    chk("t3_drain", 64'(sb_q.size()), 64'd0);

    // backpressure: third word must wait, outputs held
    out_ready = 1'b0;
    send(32'h0000_0010, 1'b1);
    send(32'h0000_0028, 1'b1);
    in_valid = 1'b1; in_code = 32'h8000_0003; correct_en = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(5);
    chk("bp_drain", 64'(sb_q.size()), 64'd0);

    // random words with random backpressure and occasional counter clears
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send($urandom, 1'($urandom_range(0, 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          clr_cnt   = ($urandom_range(0, 15) == 0);
        end
      end
    join
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    idle(6);
    chk("rand_drain", 64'(sb_q.size()), 64'd0);

    // reset with two words in flight
    out_ready = 1'b0;
    send(32'h0000_0001, 1'b1);
    send(32'h0000_0006, 1'b1);
    if (cnt_corr == 0) begin
      // make sure the counters have something to clear
      out_ready = 1'b1;
      idle(3);
      out_ready = 1'b0;
      send(32'h0000_0001, 1'b1);
      send(32'h0000_0006, 1'b1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_hold_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_cnt_corr", cnt_corr, 16'd0);
    chk("rst2_cnt_uncorr", cnt_uncorr, 16'd0);
    chk("rst2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    idle(5);

    // narrow instance: out-of-range syndrome, then counter saturation and clear priority
    bsend(13'h0112, 1'b0, {8'h00, 4'hD, 4'h0, 1'b0, 1'b1});
    chk("b_cnt_uncorr", b_cnt_uncorr, 2'd1);
    for (int k = 1; k <= 5; k++) begin
      bsend(13'h0008, 1'b0, {8'h00, 4'h3, 4'h3, 1'b1, 1'b0});
      chk("b_cnt_corr_sat", b_cnt_corr, (k > 3) ? 2'd3 : 2'(k));
    end
    bsend(13'h0008, 1'b1, {8'h00, 4'h3, 4'h3, 1'b1, 1'b0});
    chk("b_cnt_corr_clr", b_cnt_corr, 2'd0);
    chk("b_cnt_uncorr_clr", b_cnt_uncorr, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
